// File: rtl/cache_ctrl.sv
// 2-way set-associative write-through data cache controller.
// Owns tag/valid/LRU/data arrays and sequences CPU and memory handshakes.
module cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SETS  = 1 << IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_victim;

  logic [SETS-1:0]   r_valid0;
  logic [SETS-1:0]   r_valid1;
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag0  [SETS];
  logic [TAG_W-1:0]  r_tag1  [SETS];
  logic [DATA_W-1:0] r_data0 [SETS];
  logic [DATA_W-1:0] r_data1 [SETS];

  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_hit;
  logic              w_way;
  logic              w_vict;
  logic              w_fill;
  logic              w_whit;

  assign w_idx  = r_addr[IDX_W-1:0];
  assign w_tag  = r_addr[ADDR_W-1:IDX_W];
  assign w_hit0 = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1 = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  // A line is only allocated on a miss, so both ways never hit together.
  assign w_way  = w_hit1;
  assign w_vict = !r_valid0[w_idx] ? 1'b0 :
                  !r_valid1[w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_fill = (r_state == S_MEM_RD) && mem_ack;
  assign w_whit = (r_state == S_LOOKUP) && r_we && w_hit;

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // Tag and data storage; contents only matter where valid is set.
  always_ff @(posedge clk) begin
    if (w_whit) begin
      if (w_way) r_data1[w_idx] <= r_wdata;
      else       r_data0[w_idx] <= r_wdata;
    end
    if (w_fill) begin
      if (r_victim) begin
        r_data1[w_idx] <= mem_rdata;
        r_tag1[w_idx]  <= w_tag;
      end else begin
        r_data0[w_idx] <= mem_rdata;
        r_tag0[w_idx]  <= w_tag;
      end
    end
  end

  // Control FSM, valid/LRU state, memory port and statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_victim    <= 1'b0;
      r_valid0    <= '0;
      r_valid1    <= '0;
      r_lru       <= '0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
          end else if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
          end
          if (r_we) begin
            if (w_hit) r_lru[w_idx] <= ~w_way;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= S_MEM_WR;
          end else if (w_hit) begin
            r_cpu_rdata  <= w_way ? r_data1[w_idx] : r_data0[w_idx];
            r_lru[w_idx] <= ~w_way;
            r_state      <= S_RESP;
          end else begin
            r_victim   <= w_vict;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_addr;
            r_state    <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            if (r_victim) r_valid1[w_idx] <= 1'b1;
            else          r_valid0[w_idx] <= 1'b1;
            r_lru[w_idx] <= ~r_victim;
            r_cpu_rdata  <= mem_rdata;
            r_mem_req    <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          r_valid0 <= '0;
          r_valid1 <= '0;
          r_lru    <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus random traffic
// against a recency-list cache model and a word-array memory.
module tb_cache_ctrl;

  localparam int CNT_W = 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  cache_ctrl #(.ADDR_W(8), .DATA_W(32), .IDX_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  int mtag [8][2];
  int mcnt [8];
  int m_hit;
  int m_miss;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) mcnt[s] = 0;
  endtask

  task automatic access(input logic we, input logic [7:0] a,
                        input logic [31:0] wd);
    int set, tag, pos, req_c, ack_c, rdy_c, nreq, lat;
    bit hit, exp_mem, prev;
    logic [31:0] exp_rd, rd;
    set = int'(a[2:0]);
    tag = int'(a[7:3]);
    pos = -1;
    for (int i = 0; i < mcnt[set]; i++)
      if (mtag[set][i] == tag) pos = i;
    hit = (pos >= 0);
    exp_mem = we || !hit;
    exp_rd = mem[a];
    if (hit) begin
      if (m_hit < MAXC) m_hit++;
      if (pos == 1) begin
        mtag[set][1] = mtag[set][0];
        mtag[set][0] = tag;
      end
    end else begin
      if (m_miss < MAXC) m_miss++;
      if (!we) begin
        mtag[set][1] = mtag[set][0];
        mtag[set][0] = tag;
        if (mcnt[set] < 2) mcnt[set]++;
      end
    end
    check("idle_before", busy, 0);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    req_c = -1; ack_c = -1; rdy_c = -1; nreq = 0; prev = 0;
    rd = '0;
    lat = $urandom_range(1, 4);
    for (int c = 1; c <= 40 && rdy_c < 0; c++) begin
      @(negedge clk);
      mem_ack = 0;
      mem_rdata = $urandom;
      if (cpu_ready) begin
        rdy_c = c;
        rd = cpu_rdata;
        cpu_req = 0;
        check("req_drop", mem_req, 0);
      end
      if (mem_req && !prev) begin
        nreq++;
        req_c = c;
        check("mem_we", mem_we, we);
        check("mem_addr", mem_addr, a);
        if (we) check("mem_wdata", mem_wdata, wd);
      end
      prev = mem_req;
      if (mem_req && ack_c < 0 && c == req_c + lat) begin
        mem_ack = 1;
        mem_rdata = mem[mem_addr];
        ack_c = c;
      end
    end
    cpu_req = 0;
    mem_ack = 0;
    check("ready_seen", rdy_c >= 0, 1);
    check("nreq", nreq, exp_mem ? 1 : 0);
    if (exp_mem) check("lat_mem", rdy_c, ack_c + 1);
    else         check("lat_hit", rdy_c, 2);
    if (!we) check("rdata", rd, exp_rd);
    if (we) mem[a] = wd;
    check("hit_cnt", hit_cnt, m_hit);
    check("miss_cnt", miss_cnt, m_miss);
    @(negedge clk);
    check("ready_pulse", cpu_ready, 0);
  endtask

  task automatic do_flush();
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy", busy, 1);
    check("flush_rdy", cpu_ready, 0);
    @(negedge clk);
    check("flush_done", busy, 0);
    check("flush_rdy2", cpu_ready, 0);
    model_clear();
  endtask

  task automatic reset_mid_read(input logic [7:0] a);
    int seen;
    seen = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = a; cpu_wdata = '0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    check("rst_mem_rd", seen, 1);
    @(negedge clk);
    #1 rstn = 0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    cpu_req = 0;
    @(negedge clk);
    rstn = 1;
    mem_ack = 1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 0;
    for (int c = 0; c < 5; c++) begin
      check("late_ack_rdy", cpu_ready, 0);
      check("late_ack_req", mem_req, 0);
      @(negedge clk);
    end
    model_clear();
    m_hit = 0;
    m_miss = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_clear();
    m_hit = 0; m_miss = 0;
    rstn = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wdata = '0; flush = 0; mem_ack = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_busy0", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_hit0", hit_cnt, 0);
    check("rst_miss0", miss_cnt, 0);

    mem[8'h13] = 32'hDEADBEEF;
    access(0, 8'h13, 0);
    access(0, 8'h13, 0);
    access(1, 8'h20, 32'h55);
    access(0, 8'h20, 0);
    access(0, 8'h05, 0);
    access(1, 8'h05, 32'h1234);
    access(0, 8'h05, 0);
    access(0, 8'h01, 0);
    access(0, 8'h09, 0);
    access(0, 8'h01, 0);
    access(0, 8'h11, 0);
    access(0, 8'h01, 0);
    access(0, 8'h09, 0);
    access(0, 8'h02, 0);
    do_flush();
    access(0, 8'h02, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      access(1'($urandom_range(0, 2) == 0),
             8'($urandom_range(0, 31)), $urandom);
    end
    check("hit_sat", hit_cnt, MAXC);
    check("miss_sat", miss_cnt, MAXC);

    do_flush();
    reset_mid_read(8'h2A);
    access(0, 8'h2A, 0);
    access(0, 8'h2A, 0);
    access(1, 8'h2A, 32'hCAFE0001);
    access(0, 8'h2A, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
